// File: rtl/cnn_pkg.sv
// Shared constants, FSM state encoding and the read-tag layout for the
// CNN window register array.
package cnn_pkg;

    localparam int WIN_ELEMS   = 9;
    localparam int SLIDE_ELEMS = 3;
    localparam int IDX_W       = 4;
    localparam int BSEL_W      = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        FILL = 3'b010,
        PEND = 3'b100
    } state_e;

    // Address-side information that must line up with the SRAM read data.
    typedef struct packed {
        logic              wr_en;
        logic [IDX_W-1:0]  idx;
        logic [BSEL_W-1:0] bsel;
        logic              full;
    } rd_tag_t;

    function automatic logic [CNT_W-1:0] win_target(input logic full);
        return full ? CNT_W'(WIN_ELEMS) : CNT_W'(SLIDE_ELEMS);
    endfunction

endpackage

// File: rtl/cnn_rdlat_pipe.sv
// DEPTH-stage delay line that aligns address-side tags with SRAM read data;
// a synchronous flush empties every stage, including the one being loaded.
module cnn_rdlat_pipe #(
    parameter int W     = 9,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_q <= '{default: '0};
        end else if (flush_i) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cnn_win_regarray.sv
// Captures SRAM read words into a 3x3 window array and hands completed windows
// to the PE over valid/ready. Define CNN_WIN_DBGCNT_EN for the win_cnt_o counter.
module cnn_win_regarray
    import cnn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                      SYS_CLK,
    input  logic                      SYS_NRST,
    input  logic                      genaddr_start,
    input  logic                      addr_valid_i,
    input  logic                      full_win_i,
    input  logic [IDX_W-1:0]          wr_idx_i,
    input  logic [BSEL_W-1:0]         bitsel_i,
    input  logic [DATA_W-1:0]         rsram_rdata_i,
    input  logic                      win_ready_i,
    output logic                      win_valid_o,
    output logic [WIN_ELEMS*DATA_W-1:0] win_data_o,
    output logic [BSEL_W-1:0]         win_bitsel_o,
    output logic                      stall_o,
    output logic                      err_o
`ifdef CNN_WIN_DBGCNT_EN
    ,
    output logic [15:0]               win_cnt_o
`endif
);

    rd_tag_t tag_in;
    rd_tag_t d_tag;

    assign tag_in = '{wr_en: addr_valid_i, idx: wr_idx_i, bsel: bitsel_i, full: full_win_i};

    cnn_rdlat_pipe #(
        .W     ($bits(rd_tag_t)),
        .DEPTH (RD_LAT)
    ) u_rdlat_pipe (
        .clk_i   (SYS_CLK),
        .rst_n_i (SYS_NRST),
        .flush_i (genaddr_start),
        .d_i     (tag_in),
        .q_o     (d_tag)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   arr_q [WIN_ELEMS];
    logic [DATA_W-1:0]   arr_d [WIN_ELEMS];
    logic [DATA_W-1:0]   buf_q [WIN_ELEMS];
    logic [DATA_W-1:0]   buf_d [WIN_ELEMS];
    logic [BSEL_W-1:0]   bsel_q, bsel_d;
    logic [BSEL_W-1:0]   pend_bsel_q, pend_bsel_d;
    logic                valid_q, valid_d;
    logic                stall_q, stall_d;
    logic                err_q, err_d;

    logic                idx_ok;
    logic                out_free;
    logic                accept;
    logic [CNT_W-1:0]    cnt_inc;

    assign idx_ok   = d_tag.idx <= IDX_W'(WIN_ELEMS - 1);
    assign accept   = valid_q & win_ready_i;
    assign out_free = !valid_q | win_ready_i;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // NOTE: every always_comb target gets its default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arr_d       = arr_q;
        buf_d       = buf_q;
        bsel_d      = bsel_q;
        pend_bsel_d = pend_bsel_q;
        valid_d     = valid_q;
        err_d       = err_q;

        if (accept) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: ;
            FILL: begin
                if (d_tag.wr_en) begin
                    if (!idx_ok) begin
                        err_d = 1'b1;
                    end else begin
                        arr_d[d_tag.idx] = rsram_rdata_i;
                        cnt_d            = cnt_inc;
                        if (cnt_inc == win_target(d_tag.full)) begin
                            if (out_free) begin
                                buf_d   = arr_d;
                                bsel_d  = d_tag.bsel;
                                valid_d = 1'b1;
                                cnt_d   = '0;
                            end else begin
                                state_d     = PEND;
                                pend_bsel_d = d_tag.bsel;
                            end
                        end
                    end
                end
            end
            PEND: begin
                // Generator should have halted; anything still in flight is lost.
                if (d_tag.wr_en) begin
                    err_d = 1'b1;
                end
                if (win_ready_i) begin
                    buf_d   = arr_q;
                    bsel_d  = pend_bsel_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        if (genaddr_start) begin
            state_d = FILL;
            cnt_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
            arr_d   = '{default: '0};
        end

        // Warn the generator one write early when the buffer is still occupied.
        stall_d = (state_d == PEND) ||
                  ((state_d == FILL) && valid_d && !win_ready_i &&
                   (cnt_d == win_target(full_win_i) - CNT_W'(1)));
    end

    // NOTE: the window array and output buffer are small register files, so
    // they are reset along with the control state.
    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            arr_q       <= '{default: '0};
            buf_q       <= '{default: '0};
            bsel_q      <= '0;
            pend_bsel_q <= '0;
            valid_q     <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arr_q       <= arr_d;
            buf_q       <= buf_d;
            bsel_q      <= bsel_d;
            pend_bsel_q <= pend_bsel_d;
            valid_q     <= valid_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    assign win_valid_o  = valid_q;
    assign win_bitsel_o = bsel_q;
    assign stall_o      = stall_q;
    assign err_o        = err_q;

    for (genvar k = 0; k < WIN_ELEMS; k++) begin : g_pack
        assign win_data_o[k*DATA_W +: DATA_W] = buf_q[k];
    end

`ifdef CNN_WIN_DBGCNT_EN
    logic [15:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (accept && (wcnt_q != 16'hFFFF)) begin
            wcnt_d = wcnt_q + 16'd1;
        end
        if (genaddr_start) begin
            wcnt_d = '0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign win_cnt_o = wcnt_q;
`endif

endmodule

// File: tb/tb_cnn_win_regarray.sv
// Directed self-checking bench for cnn_win_regarray (DATA_W=8, RD_LAT=1).
module tb_cnn_win_regarray;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        genaddr_start;
    logic        addr_valid;
    logic        full_win;
    logic [3:0]  wr_idx;
    logic [2:0]  bitsel;
    logic [7:0]  rdata;
    logic        win_ready;
    logic        win_valid;
    logic [71:0] win_data;
    logic [2:0]  win_bitsel;
    logic        stall;
    logic        err;
`ifdef CNN_WIN_DBGCNT_EN
    logic [15:0] win_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cnn_win_regarray #(
        .DATA_W (8),
        .RD_LAT (1)
    ) dut (
        .SYS_CLK       (clk),
        .SYS_NRST      (rst_n),
        .genaddr_start (genaddr_start),
        .addr_valid_i  (addr_valid),
        .full_win_i    (full_win),
        .wr_idx_i      (wr_idx),
        .bitsel_i      (bitsel),
        .rsram_rdata_i (rdata),
        .win_ready_i   (win_ready),
        .win_valid_o   (win_valid),
        .win_data_o    (win_data),
        .win_bitsel_o  (win_bitsel),
        .stall_o       (stall),
        .err_o         (err)
`ifdef CNN_WIN_DBGCNT_EN
        ,
        .win_cnt_o     (win_cnt)
`endif
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one address; its read word appears on rdata the following cycle.
    task automatic wr(input logic [3:0] idx, input logic [7:0] data,
                      input logic full, input logic [2:0] bs);
        addr_valid = 1'b1;
        wr_idx     = idx;
        full_win   = full;
        bitsel     = bs;
        tick();
        addr_valid = 1'b0;
        rdata      = data;
    endtask

    task automatic start_pass();
        genaddr_start = 1'b1;
        tick();
        genaddr_start = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        genaddr_start = 1'b0;
        addr_valid    = 1'b0;
        full_win      = 1'b0;
        wr_idx        = '0;
        bitsel        = '0;
        rdata         = '0;
        win_ready     = 1'b0;
        #12;
        check("rst_valid",  72'(win_valid),  72'd0);
        check("rst_data",   win_data,        72'd0);
        check("rst_bitsel", 72'(win_bitsel), 72'd0);
        check("rst_stall",  72'(stall),      72'd0);
        check("rst_err",    72'(err),        72'd0);
        rst_n = 1'b1;
        tick();

        // Full 9-element window, PE always ready.
        start_pass();
        win_ready = 1'b1;
        for (int i = 0; i < 9; i++) wr(4'(i), 8'h10 + 8'(i), 1'b1, 3'd5);
        check("full_valid_early", 72'(win_valid), 72'd0);
        tick();
        check("full_valid",  72'(win_valid),  72'd1);
        check("full_data",   win_data,        72'h18_17_16_15_14_13_12_11_10);
        check("full_bitsel", 72'(win_bitsel), 72'd5);
        check("full_stall",  72'(stall),      72'd0);
        tick();
        check("full_accept_drop", 72'(win_valid), 72'd0);

        // Slide window: only entries 2/5/8 are replaced.
        wr(4'd2, 8'hAA, 1'b0, 3'd2);
        wr(4'd5, 8'hBB, 1'b0, 3'd2);
        wr(4'd8, 8'hCC, 1'b0, 3'd2);
        tick();
        check("slide_valid",  72'(win_valid),  72'd1);
        check("slide_data",   win_data,        72'hCC_17_16_BB_14_13_AA_11_10);
        check("slide_bitsel", 72'(win_bitsel), 72'd2);
        tick();
        check("slide_accept_drop", 72'(win_valid), 72'd0);

        // Back-pressure: window A presented, window B completes while A is held.
        win_ready = 1'b0;
        wr(4'd0, 8'h01, 1'b0, 3'd3);
        wr(4'd1, 8'h02, 1'b0, 3'd3);
        wr(4'd2, 8'h03, 1'b0, 3'd3);
        tick();
        check("bpA_valid", 72'(win_valid), 72'd1);
        check("bpA_data",  win_data,       72'hCC_17_16_BB_14_13_03_02_01);
        wr(4'd6, 8'h66, 1'b0, 3'd4);
        wr(4'd7, 8'h77, 1'b0, 3'd4);
        wr(4'd8, 8'h88, 1'b0, 3'd4);
        tick();
        check("pend_valid",  72'(win_valid),  72'd1);
        check("pend_data",   win_data,        72'hCC_17_16_BB_14_13_03_02_01);
        check("pend_bitsel", 72'(win_bitsel), 72'd3);
        check("pend_stall",  72'(stall),      72'd1);
        check("pend_err",    72'(err),        72'd0);
        tick();
        check("pend_hold_data", win_data, 72'hCC_17_16_BB_14_13_03_02_01);

        // A write landing in PEND is dropped and flagged.
        wr(4'd0, 8'hEE, 1'b0, 3'd7);
        tick();
        check("drop_err",   72'(err),   72'd1);
        check("drop_stall", 72'(stall), 72'd1);
        check("drop_data",  win_data,   72'hCC_17_16_BB_14_13_03_02_01);
        win_ready = 1'b1;
        tick();
        check("rel_valid",  72'(win_valid),  72'd1);
        check("rel_data",   win_data,        72'h88_77_66_BB_14_13_03_02_01);
        check("rel_bitsel", 72'(win_bitsel), 72'd4);
        check("rel_stall",  72'(stall),      72'd0);
        tick();
        check("rel_accept_drop", 72'(win_valid), 72'd0);
        check("err_sticky",      72'(err),       72'd1);
`ifdef CNN_WIN_DBGCNT_EN
        check("dbg_cnt_accepts", 72'(win_cnt), 72'd4);
`endif

        // New pass clears err; an out-of-range index is not written or counted.
        win_ready = 1'b0;
        start_pass();
        check("start_err_clr", 72'(err), 72'd0);
`ifdef CNN_WIN_DBGCNT_EN
        check("dbg_cnt_clr", 72'(win_cnt), 72'd0);
`endif
        wr(4'd12, 8'h55, 1'b1, 3'd1);
        tick();
        check("badidx_err",   72'(err),       72'd1);
        check("badidx_valid", 72'(win_valid), 72'd0);
        for (int i = 0; i < 8; i++) wr(4'(i), 8'h20 + 8'(i), 1'b1, 3'd1);
        tick();
        check("badidx_not_counted", 72'(win_valid), 72'd0);
        wr(4'd8, 8'h28, 1'b1, 3'd1);
        tick();
        check("badidx_win_valid", 72'(win_valid), 72'd1);
        check("badidx_win_data",  win_data,       72'h28_27_26_25_24_23_22_21_20);
        check("badidx_err_hold",  72'(err),       72'd1);

        // Restart after 5 of 9 writes: count returns to 0, window withdrawn.
        for (int i = 0; i < 5; i++) wr(4'(i), 8'h30 + 8'(i), 1'b1, 3'd1);
        tick();
        check("mid_hold_data", win_data, 72'h28_27_26_25_24_23_22_21_20);
        start_pass();
        check("restart_valid", 72'(win_valid), 72'd0);
        check("restart_err",   72'(err),       72'd0);
        for (int i = 0; i < 9; i++) wr(4'(i), 8'h40 + 8'(i), 1'b1, 3'd6);
        check("restart_no_early", 72'(win_valid), 72'd0);
        tick();
        check("restart_valid2",  72'(win_valid),  72'd1);
        check("restart_data",    win_data,        72'h48_47_46_45_44_43_42_41_40);
        check("restart_bitsel",  72'(win_bitsel), 72'd6);
        win_ready = 1'b1;
        tick();
        check("restart_accept_drop", 72'(win_valid), 72'd0);
`ifdef CNN_WIN_DBGCNT_EN
        check("dbg_cnt_final", 72'(win_cnt), 72'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
